// File: rtl/axi_chan_match_pkg.sv
// Shared constants for the AXI channel match checker: channel indices and counter widths.
package axi_chan_match_pkg;

  localparam int unsigned ChAw  = 0;
  localparam int unsigned ChW   = 1;
  localparam int unsigned ChB   = 2;
  localparam int unsigned ChAr  = 3;
  localparam int unsigned ChR   = 4;
  localparam int unsigned NumCh = 5;

  localparam int unsigned ErrCntWidth   = 16;
  localparam int unsigned MatchCntWidth = 16;

  function automatic logic [2:0] count_ones(input logic [NumCh-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NumCh; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/chan_match_fifo.sv
// One checked channel: expectation FIFO with bypass, masked compare and sticky error flags.
// AXI_CHAN_MATCH_CNT_EN adds a saturating successful-compare counter.
module chan_match_fifo
  import axi_chan_match_pkg::*;
#(
  parameter int unsigned Width     = 64,
  parameter int unsigned Depth     = 16,
  parameter int unsigned IdWidth   = 3,
  parameter int unsigned CompareId = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             prod_fire_i,
  input  logic [Width-1:0] prod_data_i,
  input  logic             cons_fire_i,
  input  logic [Width-1:0] cons_data_i,
  output logic             mismatch_o,
  output logic             unexpected_o,
  output logic             overflow_o,
  output logic             err_o,
  output logic             empty_o
`ifdef AXI_CHAN_MATCH_CNT_EN
  ,
  output logic [MatchCntWidth-1:0] match_cnt_o
`endif
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [Width-1:0] IdOnes  = Width'((1 << IdWidth) - 1);
  localparam logic [Width-1:0] CmpMask = (CompareId != 0) ? '1 : ~IdOnes;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr, r_rptr;
  logic [CntW-1:0]  r_cnt;
  logic             r_mismatch, r_unexp, r_ovf;

  logic             w_empty, w_full, w_bypass, w_pop, w_push;
  logic             w_unexp, w_ovf, w_cmp, w_mis;
  logic [Width-1:0] w_exp;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CntW'(Depth));
  assign w_bypass = prod_fire_i & cons_fire_i & w_empty;
  assign w_pop    = cons_fire_i & ~w_empty;
  assign w_unexp  = cons_fire_i & w_empty & ~prod_fire_i;
  // A full FIFO still accepts a push when the same cycle pops its head.
  assign w_ovf    = prod_fire_i & w_full & ~cons_fire_i;
  assign w_push   = prod_fire_i & ~w_bypass & ~w_ovf;

  assign w_exp = w_bypass ? prod_data_i : r_mem[r_rptr];
  assign w_cmp = w_bypass | w_pop;
  assign w_mis = w_cmp & (|((w_exp ^ cons_data_i) & CmpMask));

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= prod_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_mismatch <= 1'b0;
      r_unexp    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
      r_mismatch <= r_mismatch | w_mis;
      r_unexp    <= r_unexp | w_unexp;
      r_ovf      <= r_ovf | w_ovf;
    end
  end

`ifdef AXI_CHAN_MATCH_CNT_EN
  logic [MatchCntWidth-1:0] r_match_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_match_cnt <= '0;
    end else if (w_cmp && !w_mis && (r_match_cnt != '1)) begin
      r_match_cnt <= r_match_cnt + MatchCntWidth'(1);
    end
  end

  assign match_cnt_o = r_match_cnt;
`endif

  assign mismatch_o   = r_mismatch;
  assign unexpected_o = r_unexp;
  assign overflow_o   = r_ovf;
  // Channel-level checks are mutually exclusive, so one bit per channel per cycle suffices.
  assign err_o        = w_mis | w_unexp | w_ovf;
  assign empty_o      = w_empty;

endmodule

// File: rtl/axi_chan_match_checker.sv
// Passive AXI4 two-point match checker: requests A->B, responses B->A, compared in order.
// Define AXI_CHAN_MATCH_CNT_EN to add per-channel successful-compare counters (match_cnt_o).
module axi_chan_match_checker
  import axi_chan_match_pkg::*;
#(
  parameter int unsigned AwWidth   = 64,
  parameter int unsigned WWidth    = 73,
  parameter int unsigned BWidth    = 8,
  parameter int unsigned ArWidth   = 64,
  parameter int unsigned RWidth    = 72,
  parameter int unsigned Depth     = 16,
  parameter int unsigned IdWidth   = 3,
  parameter int unsigned CompareId = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AwWidth-1:0]     a_aw_data_i,
  input  logic                   a_aw_valid_i,
  input  logic                   a_aw_ready_i,
  input  logic [AwWidth-1:0]     b_aw_data_i,
  input  logic                   b_aw_valid_i,
  input  logic                   b_aw_ready_i,
  input  logic [WWidth-1:0]      a_w_data_i,
  input  logic                   a_w_valid_i,
  input  logic                   a_w_ready_i,
  input  logic [WWidth-1:0]      b_w_data_i,
  input  logic                   b_w_valid_i,
  input  logic                   b_w_ready_i,
  input  logic [BWidth-1:0]      a_b_data_i,
  input  logic                   a_b_valid_i,
  input  logic                   a_b_ready_i,
  input  logic [BWidth-1:0]      b_b_data_i,
  input  logic                   b_b_valid_i,
  input  logic                   b_b_ready_i,
  input  logic [ArWidth-1:0]     a_ar_data_i,
  input  logic                   a_ar_valid_i,
  input  logic                   a_ar_ready_i,
  input  logic [ArWidth-1:0]     b_ar_data_i,
  input  logic                   b_ar_valid_i,
  input  logic                   b_ar_ready_i,
  input  logic [RWidth-1:0]      a_r_data_i,
  input  logic                   a_r_valid_i,
  input  logic                   a_r_ready_i,
  input  logic [RWidth-1:0]      b_r_data_i,
  input  logic                   b_r_valid_i,
  input  logic                   b_r_ready_i,
  output logic [NumCh-1:0]       mismatch_o,
  output logic [NumCh-1:0]       unexpected_o,
  output logic [NumCh-1:0]       overflow_o,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  output logic                   idle_o
`ifdef AXI_CHAN_MATCH_CNT_EN
  ,
  output logic [NumCh*MatchCntWidth-1:0] match_cnt_o
`endif
);

  logic [NumCh-1:0]       w_prod_fire, w_cons_fire, w_err, w_empty;
  logic [2:0]             w_err_num;
  logic [ErrCntWidth:0]   w_err_sum;
  logic [ErrCntWidth-1:0] r_err_cnt;

  // Requests are produced on A; responses are produced on B.
  assign w_prod_fire[ChAw] = a_aw_valid_i & a_aw_ready_i;
  assign w_cons_fire[ChAw] = b_aw_valid_i & b_aw_ready_i;
  assign w_prod_fire[ChW]  = a_w_valid_i & a_w_ready_i;
  assign w_cons_fire[ChW]  = b_w_valid_i & b_w_ready_i;
  assign w_prod_fire[ChB]  = b_b_valid_i & b_b_ready_i;
  assign w_cons_fire[ChB]  = a_b_valid_i & a_b_ready_i;
  assign w_prod_fire[ChAr] = a_ar_valid_i & a_ar_ready_i;
  assign w_cons_fire[ChAr] = b_ar_valid_i & b_ar_ready_i;
  assign w_prod_fire[ChR]  = b_r_valid_i & b_r_ready_i;
  assign w_cons_fire[ChR]  = a_r_valid_i & a_r_ready_i;

  chan_match_fifo #(
    .Width(AwWidth), .Depth(Depth), .IdWidth(IdWidth), .CompareId(CompareId)
  ) u_aw (
    .clk_i(clk_i), .rst_i(rst_i),
    .prod_fire_i(w_prod_fire[ChAw]), .prod_data_i(a_aw_data_i),
    .cons_fire_i(w_cons_fire[ChAw]), .cons_data_i(b_aw_data_i),
    .mismatch_o(mismatch_o[ChAw]), .unexpected_o(unexpected_o[ChAw]),
    .overflow_o(overflow_o[ChAw]), .err_o(w_err[ChAw]), .empty_o(w_empty[ChAw])
`ifdef AXI_CHAN_MATCH_CNT_EN
    , .match_cnt_o(match_cnt_o[ChAw*MatchCntWidth +: MatchCntWidth])
`endif
  );

  chan_match_fifo #(
    .Width(WWidth), .Depth(Depth), .IdWidth(IdWidth), .CompareId(CompareId)
  ) u_w (
    .clk_i(clk_i), .rst_i(rst_i),
    .prod_fire_i(w_prod_fire[ChW]), .prod_data_i(a_w_data_i),
    .cons_fire_i(w_cons_fire[ChW]), .cons_data_i(b_w_data_i),
    .mismatch_o(mismatch_o[ChW]), .unexpected_o(unexpected_o[ChW]),
    .overflow_o(overflow_o[ChW]), .err_o(w_err[ChW]), .empty_o(w_empty[ChW])
`ifdef AXI_CHAN_MATCH_CNT_EN
    , .match_cnt_o(match_cnt_o[ChW*MatchCntWidth +: MatchCntWidth])
`endif
  );

  chan_match_fifo #(
    .Width(BWidth), .Depth(Depth), .IdWidth(IdWidth), .CompareId(CompareId)
  ) u_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .prod_fire_i(w_prod_fire[ChB]), .prod_data_i(b_b_data_i),
    .cons_fire_i(w_cons_fire[ChB]), .cons_data_i(a_b_data_i),
    .mismatch_o(mismatch_o[ChB]), .unexpected_o(unexpected_o[ChB]),
    .overflow_o(overflow_o[ChB]), .err_o(w_err[ChB]), .empty_o(w_empty[ChB])
`ifdef AXI_CHAN_MATCH_CNT_EN
    , .match_cnt_o(match_cnt_o[ChB*MatchCntWidth +: MatchCntWidth])
`endif
  );

  chan_match_fifo #(
    .Width(ArWidth), .Depth(Depth), .IdWidth(IdWidth), .CompareId(CompareId)
  ) u_ar (
    .clk_i(clk_i), .rst_i(rst_i),
    .prod_fire_i(w_prod_fire[ChAr]), .prod_data_i(a_ar_data_i),
    .cons_fire_i(w_cons_fire[ChAr]), .cons_data_i(b_ar_data_i),
    .mismatch_o(mismatch_o[ChAr]), .unexpected_o(unexpected_o[ChAr]),
    .overflow_o(overflow_o[ChAr]), .err_o(w_err[ChAr]), .empty_o(w_empty[ChAr])
`ifdef AXI_CHAN_MATCH_CNT_EN
    , .match_cnt_o(match_cnt_o[ChAr*MatchCntWidth +: MatchCntWidth])
`endif
  );

  chan_match_fifo #(
    .Width(RWidth), .Depth(Depth), .IdWidth(IdWidth), .CompareId(CompareId)
  ) u_r (
    .clk_i(clk_i), .rst_i(rst_i),
    .prod_fire_i(w_prod_fire[ChR]), .prod_data_i(b_r_data_i),
    .cons_fire_i(w_cons_fire[ChR]), .cons_data_i(a_r_data_i),
    .mismatch_o(mismatch_o[ChR]), .unexpected_o(unexpected_o[ChR]),
    .overflow_o(overflow_o[ChR]), .err_o(w_err[ChR]), .empty_o(w_empty[ChR])
`ifdef AXI_CHAN_MATCH_CNT_EN
    , .match_cnt_o(match_cnt_o[ChR*MatchCntWidth +: MatchCntWidth])
`endif
  );

  assign w_err_num = count_ones(w_err);
  assign w_err_sum = {1'b0, r_err_cnt} + (ErrCntWidth + 1)'(w_err_num);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_cnt <= '0;
    end else if (w_err_sum[ErrCntWidth]) begin
      r_err_cnt <= '1;
    end else begin
      r_err_cnt <= w_err_sum[ErrCntWidth-1:0];
    end
  end

  assign err_cnt_o = r_err_cnt;
  assign idle_o    = &w_empty;

endmodule

// File: tb/tb_axi_chan_match_checker.sv
// Self-checking bench: two checkers (ID compared / ID masked) on shared stimulus vs a queue model.
module tb_axi_chan_match_checker;

  localparam int unsigned Depth = 16;

  logic        clk;
  logic        rst;
  logic [79:0] a_data [5];
  logic [79:0] b_data [5];
  logic [4:0]  a_valid, a_ready, b_valid, b_ready;

  logic [4:0]  mis0, unx0, ovf0, mis1, unx1, ovf1;
  logic [15:0] err0, err1;
  logic        idle0, idle1;
`ifdef AXI_CHAN_MATCH_CNT_EN
  logic [79:0] mcnt0, mcnt1;
`endif

  // Model state: one shared expectation queue per channel, per-DUT flags and error totals.
  logic [79:0] mq [5][$];
  logic [4:0]  em [2];
  logic [4:0]  eu, eo;
  int          ee [2];

  int n_cmp;
  int n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  axi_chan_match_checker #(.Depth(Depth), .CompareId(1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .a_aw_data_i(a_data[0][63:0]), .a_aw_valid_i(a_valid[0]), .a_aw_ready_i(a_ready[0]),
    .b_aw_data_i(b_data[0][63:0]), .b_aw_valid_i(b_valid[0]), .b_aw_ready_i(b_ready[0]),
    .a_w_data_i(a_data[1][72:0]), .a_w_valid_i(a_valid[1]), .a_w_ready_i(a_ready[1]),
    .b_w_data_i(b_data[1][72:0]), .b_w_valid_i(b_valid[1]), .b_w_ready_i(b_ready[1]),
    .a_b_data_i(a_data[2][7:0]), .a_b_valid_i(a_valid[2]), .a_b_ready_i(a_ready[2]),
    .b_b_data_i(b_data[2][7:0]), .b_b_valid_i(b_valid[2]), .b_b_ready_i(b_ready[2]),
    .a_ar_data_i(a_data[3][63:0]), .a_ar_valid_i(a_valid[3]), .a_ar_ready_i(a_ready[3]),
    .b_ar_data_i(b_data[3][63:0]), .b_ar_valid_i(b_valid[3]), .b_ar_ready_i(b_ready[3]),
    .a_r_data_i(a_data[4][71:0]), .a_r_valid_i(a_valid[4]), .a_r_ready_i(a_ready[4]),
    .b_r_data_i(b_data[4][71:0]), .b_r_valid_i(b_valid[4]), .b_r_ready_i(b_ready[4]),
    .mismatch_o(mis0), .unexpected_o(unx0), .overflow_o(ovf0),
    .err_cnt_o(err0), .idle_o(idle0)
`ifdef AXI_CHAN_MATCH_CNT_EN
    , .match_cnt_o(mcnt0)
`endif
  );

  axi_chan_match_checker #(.Depth(Depth), .CompareId(0)) u_dut_nid (
    .clk_i(clk), .rst_i(rst),
    .a_aw_data_i(a_data[0][63:0]), .a_aw_valid_i(a_valid[0]), .a_aw_ready_i(a_ready[0]),
    .b_aw_data_i(b_data[0][63:0]), .b_aw_valid_i(b_valid[0]), .b_aw_ready_i(b_ready[0]),
    .a_w_data_i(a_data[1][72:0]), .a_w_valid_i(a_valid[1]), .a_w_ready_i(a_ready[1]),
    .b_w_data_i(b_data[1][72:0]), .b_w_valid_i(b_valid[1]), .b_w_ready_i(b_ready[1]),
    .a_b_data_i(a_data[2][7:0]), .a_b_valid_i(a_valid[2]), .a_b_ready_i(a_ready[2]),
    .b_b_data_i(b_data[2][7:0]), .b_b_valid_i(b_valid[2]), .b_b_ready_i(b_ready[2]),
    .a_ar_data_i(a_data[3][63:0]), .a_ar_valid_i(a_valid[3]), .a_ar_ready_i(a_ready[3]),
    .b_ar_data_i(b_data[3][63:0]), .b_ar_valid_i(b_valid[3]), .b_ar_ready_i(b_ready[3]),
    .a_r_data_i(a_data[4][71:0]), .a_r_valid_i(a_valid[4]), .a_r_ready_i(a_ready[4]),
    .b_r_data_i(b_data[4][71:0]), .b_r_valid_i(b_valid[4]), .b_r_ready_i(b_ready[4]),
    .mismatch_o(mis1), .unexpected_o(unx1), .overflow_o(ovf1),
    .err_cnt_o(err1), .idle_o(idle1)
`ifdef AXI_CHAN_MATCH_CNT_EN
    , .match_cnt_o(mcnt1)
`endif
  );

  function automatic int unsigned chw(input int c);
    case (c)
      0:       return 64;
      1:       return 73;
      2:       return 8;
      3:       return 64;
      default: return 72;
    endcase
  endfunction

  function automatic logic [79:0] wmask(input int c);
    return (80'(1) << chw(c)) - 80'(1);
  endfunction

  // B and R beats originate on the B side; the rest originate on A.
  function automatic bit b_prod(input int c);
    return (c == 2) || (c == 4);
  endfunction

  function automatic logic [79:0] rand_data(input int c);
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0] & wmask(c);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  ne [2];
    bit  pf, cf, has;
    logic [79:0] pd, cd, ex;
    ne[0] = 0;
    ne[1] = 0;
    for (int c = 0; c < 5; c++) begin
      pf = b_prod(c) ? (b_valid[c] & b_ready[c]) : (a_valid[c] & a_ready[c]);
      cf = b_prod(c) ? (a_valid[c] & a_ready[c]) : (b_valid[c] & b_ready[c]);
      pd = (b_prod(c) ? b_data[c] : a_data[c]) & wmask(c);
      cd = (b_prod(c) ? a_data[c] : b_data[c]) & wmask(c);
      ex = '0;
      if (cf) begin
        has = (mq[c].size() > 0) || pf;
        if (mq[c].size() > 0) begin
          ex = mq[c].pop_front();
          if (pf) mq[c].push_back(pd);
        end else if (pf) begin
          ex = pd;
        end
        if (!has) begin
          eu[c] = 1'b1;
          ne[0]++;
          ne[1]++;
        end else begin
          if (ex != cd) begin
            em[0][c] = 1'b1;
            ne[0]++;
          end
          if (((ex ^ cd) & ~80'h7) != '0) begin
            em[1][c] = 1'b1;
            ne[1]++;
          end
        end
      end else if (pf) begin
        if (mq[c].size() == Depth) begin
          eo[c] = 1'b1;
          ne[0]++;
          ne[1]++;
        end else begin
          mq[c].push_back(pd);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      ee[d] = (ee[d] + ne[d] > 65535) ? 65535 : ee[d] + ne[d];
    end
  endtask

  function automatic bit model_idle();
    for (int c = 0; c < 5; c++) begin
      if (mq[c].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Model advances on each edge from the inputs held across it; DUT checked 3 time units later.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int c = 0; c < 5; c++) mq[c].delete();
        em[0] = '0;
        em[1] = '0;
        eu    = '0;
        eo    = '0;
        ee[0] = 0;
        ee[1] = 0;
      end else begin
        model_step();
      end
      #3;
      chk("dut0 mismatch_o",   {27'b0, mis0}, {27'b0, em[0]});
      chk("dut0 unexpected_o", {27'b0, unx0}, {27'b0, eu});
      chk("dut0 overflow_o",   {27'b0, ovf0}, {27'b0, eo});
      chk("dut0 err_cnt_o",    {16'b0, err0}, ee[0]);
      chk("dut0 idle_o",       {31'b0, idle0}, {31'b0, model_idle()});
      chk("dut1 mismatch_o",   {27'b0, mis1}, {27'b0, em[1]});
      chk("dut1 unexpected_o", {27'b0, unx1}, {27'b0, eu});
      chk("dut1 overflow_o",   {27'b0, ovf1}, {27'b0, eo});
      chk("dut1 err_cnt_o",    {16'b0, err1}, ee[1]);
      chk("dut1 idle_o",       {31'b0, idle1}, {31'b0, model_idle()});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #4;
  endtask

  task automatic clear_inputs();
    a_valid = '0;
    a_ready = '0;
    b_valid = '0;
    b_ready = '0;
    for (int c = 0; c < 5; c++) begin
      a_data[c] = '0;
      b_data[c] = '0;
    end
  endtask

  task automatic beat(input bit side_b, input int c, input logic [79:0] d);
    if (side_b) begin
      b_valid[c] = 1'b1;
      b_ready[c] = 1'b1;
      b_data[c]  = d;
    end else begin
      a_valid[c] = 1'b1;
      a_ready[c] = 1'b1;
      a_data[c]  = d;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic rand_phase(input int n, input int ppv, input int ppr, input int pcv,
                            input int pcr);
    bit pv, pr, cv, cr;
    logic [79:0] pd, cd;
    int r;
    for (int k = 0; k < n; k++) begin
      rst = ($urandom_range(0, 599) == 0);
      for (int c = 0; c < 5; c++) begin
        pv = ($urandom_range(0, 99) < ppv);
        pr = ($urandom_range(0, 99) < ppr);
        cv = ($urandom_range(0, 99) < pcv);
        cr = ($urandom_range(0, 99) < pcr);
        pd = rand_data(c);
        if (mq[c].size() > 0)  cd = mq[c][0];
        else if (pv && pr)     cd = pd;
        else                   cd = rand_data(c);
        r = $urandom_range(0, 99);
        if (r < 4)      cd = cd ^ (80'(1) << $urandom_range(0, 2));
        else if (r < 8) cd = cd ^ (80'(1) << $urandom_range(0, chw(c) - 1));
        if (b_prod(c)) begin
          b_valid[c] = pv; b_ready[c] = pr; b_data[c] = pd;
          a_valid[c] = cv; a_ready[c] = cr; a_data[c] = cd;
        end else begin
          a_valid[c] = pv; a_ready[c] = pr; a_data[c] = pd;
          b_valid[c] = cv; b_ready[c] = cr; b_data[c] = cd;
        end
      end
      cyc();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    em[0]  = '0;
    em[1]  = '0;
    eu     = '0;
    eo     = '0;
    ee[0]  = 0;
    ee[1]  = 0;
    rst    = 1'b1;
    clear_inputs();
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("reset mismatch", {27'b0, mis0}, 32'h0);
    chk("reset err_cnt", {16'b0, err0}, 32'h0);
    chk("reset idle", {31'b0, idle0}, 32'h1);

    // Same-order AW traffic
    repeat (4) cyc();
    beat(1'b0, 0, 80'h1002);
    cyc();
    clear_inputs();
    chk("aw pending idle", {31'b0, idle0}, 32'h0);
    repeat (3) cyc();
    beat(1'b1, 0, 80'h1002);
    cyc();
    clear_inputs();
    chk("aw match mismatch", {27'b0, mis0}, 32'h0);
    chk("aw match err_cnt", {16'b0, err0}, 32'h0);
    chk("aw match idle", {31'b0, idle0}, 32'h1);

    // Corrupted R beat: differs only in bit 0, inside the ID field
    do_reset();
    beat(1'b1, 4, 80'hAA);
    cyc();
    clear_inputs();
    beat(1'b0, 4, 80'hAB);
    cyc();
    clear_inputs();
    chk("r corrupt mismatch", {27'b0, mis0}, 32'h10);
    chk("r corrupt err_cnt", {16'b0, err0}, 32'h1);
    chk("r corrupt nid mismatch", {27'b0, mis1}, 32'h0);
    chk("model r corrupt", {27'b0, em[0]}, 32'h10);
    repeat (3) cyc();
    chk("r corrupt sticky", {27'b0, mis0}, 32'h10);

    // Unexpected W on B side
    do_reset();
    beat(1'b1, 1, 80'h5);
    cyc();
    clear_inputs();
    chk("w unexpected", {27'b0, unx0}, 32'h2);
    chk("w unexpected err_cnt", {16'b0, err0}, 32'h1);

    // AR overflow on the 17th push, then the first 16 drain clean
    do_reset();
    for (int i = 0; i < 17; i++) begin
      beat(1'b0, 3, 80'h100 + 80'(i * 8));
      cyc();
      if (i == 15) chk("ar full no overflow", {27'b0, ovf0}, 32'h0);
    end
    clear_inputs();
    chk("ar overflow", {27'b0, ovf0}, 32'h8);
    chk("model ar overflow", {27'b0, eo}, 32'h8);
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, 3, 80'h100 + 80'(i * 8));
      cyc();
    end
    clear_inputs();
    chk("ar drain mismatch", {27'b0, mis0}, 32'h0);
    chk("ar drain idle", {31'b0, idle0}, 32'h1);
    chk("ar drain err_cnt", {16'b0, err0}, 32'h1);

    // Bypass with beats differing only in ID
    do_reset();
    beat(1'b0, 0, 80'h2000_0005);
    beat(1'b1, 0, 80'h2000_0003);
    cyc();
    clear_inputs();
    chk("bypass id mismatch", {27'b0, mis0}, 32'h1);
    chk("bypass masked mismatch", {27'b0, mis1}, 32'h0);
    chk("bypass masked err_cnt", {16'b0, err1}, 32'h0);
    chk("bypass idle", {31'b0, idle0}, 32'h1);

    // Reset with three B beats pending
    do_reset();
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 2, 80'(8'h10 + i));
      cyc();
    end
    clear_inputs();
    chk("b pending idle", {31'b0, idle0}, 32'h0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid reset idle", {31'b0, idle0}, 32'h1);
    chk("mid reset flags", {17'b0, mis0, unx0, ovf0}, 32'h0);
    beat(1'b0, 2, 80'h10);
    cyc();
    clear_inputs();
    chk("post reset b unexpected", {27'b0, unx0}, 32'h4);

    // Randomized traffic: balanced, producer-heavy, consumer-heavy
    do_reset();
    rand_phase(3000, 70, 70, 70, 70);
    rand_phase(1500, 80, 80, 60, 15);
    rand_phase(1500, 30, 50, 85, 85);

    // Error counter saturation: five unexpected events per cycle
    do_reset();
    a_valid = 5'b10100;
    a_ready = 5'b10100;
    b_valid = 5'b01011;
    b_ready = 5'b01011;
    repeat (13200) cyc();
    clear_inputs();
    cyc();
    chk("err_cnt saturated", {16'b0, err0}, 32'hFFFF);
    chk("nid err_cnt saturated", {16'b0, err1}, 32'hFFFF);
    chk("model err saturated", ee[0], 32'hFFFF);
    chk("all unexpected", {27'b0, unx0}, 32'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
